// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: oversampled UART receiver with per-character error tags and a show-ahead receive FIFO
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   tick_ovs          oversampling strobe, OVS_FACTOR pulses per bit period
//   rx_pin            asynchronous serial input, idle high
//   parity_mode       00/11 none, 01 odd, 10 even; latched at each start edge
//   two_stop          1 = check a second stop bit; latched at each start edge
//   rx_data, rx_parity_err, rx_frame_err
//                     head-of-FIFO character and its error tags (zero when empty)
//   rx_valid, rx_ready
//                     valid/ready handshake; the head pops when both are high
//   fifo_count        current FIFO occupancy
//   overrun, overrun_clr
//                     sticky dropped-frame flag and its one-cycle clear
//   rx_break          one-cycle pulse on a detected break condition
module uart_rx_buffered #(
  parameter int DATA_BITS  = 8,
  parameter int OVS_FACTOR = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tick_ovs,
  input  logic                            rx_pin,
  input  logic [1:0]                      parity_mode,
  input  logic                            two_stop,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_parity_err,
  output logic                            rx_frame_err,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overrun,
  input  logic                            overrun_clr,
  output logic                            rx_break
);
  localparam int OSW = $clog2(OVS_FACTOR);
  localparam int BIW = $clog2(DATA_BITS);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH+1);
  localparam int EW  = DATA_BITS + 2;
  localparam logic [OSW-1:0] OS_MIDM = OSW'(OVS_FACTOR/2 - 1);
  localparam logic [OSW-1:0] OS_MID  = OSW'(OVS_FACTOR/2);
  localparam logic [OSW-1:0] OS_MIDP = OSW'(OVS_FACTOR/2 + 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVS_FACTOR - 1);
  localparam logic [BIW-1:0] LAST_BIT = BIW'(DATA_BITS - 1);
  localparam logic [CW-1:0]  DEPTH   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH, BRK_WAIT} state_t;

  state_t               state_q, state_d;
  logic                 meta_q, rxs_q, rxs_prev_q;
  logic [OSW-1:0]       os_q, os_d;
  logic [BIW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic [1:0]           pm_q, pm_d;
  logic                 ts_q, ts_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovr_q, ovr_d;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [EW-1:0]        head;
  logic                 wrap, decide, maj, par_en, brk, push, pop, wr_ok;

  // The third vote is the live sample taken on the decision tick itself.
  assign wrap   = tick_ovs && os_q == OS_LAST;
  assign decide = tick_ovs && os_q == OS_MIDP;
  assign maj    = (samp_q[0] & samp_q[1]) | (rxs_q & (samp_q[0] | samp_q[1]));
  assign par_en = pm_q[0] ^ pm_q[1];
  // par_q is cleared at each start edge, so it reads 0 whenever parity is off.
  assign brk    = ~|shift_q & ~par_q & ~maj;
  assign push   = state_q == PUSH;
  assign pop    = rx_valid && rx_ready;
  assign wr_ok  = push && (cnt_q < DEPTH || pop);

  always_comb begin
    state_d = state_q;
    os_d    = tick_ovs ? (os_q == OS_LAST ? '0 : os_q + 1'b1) : os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    samp_d  = samp_q;
    pm_d    = pm_q;
    ts_d    = ts_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = 1'b0;
    if (tick_ovs && os_q == OS_MIDM) samp_d[0] = rxs_q;
    if (tick_ovs && os_q == OS_MID) samp_d[1] = rxs_q;
    case (state_q)
      IDLE: if (rxs_prev_q && !rxs_q) begin
        state_d = START;
        os_d    = '0;
        pm_d    = parity_mode;
        ts_d    = two_stop;
        par_d   = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
      end
      START: if (decide && maj) state_d = IDLE;
        else if (wrap) begin
          state_d = DATA;
          bit_d   = '0;
        end
      DATA: begin
        if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (wrap) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = par_en ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (decide) begin
          par_d  = maj;
          perr_d = pm_q[1] ? ^{shift_q, maj} : ~^{shift_q, maj};
        end
        if (wrap) state_d = STOP1;
      end
      // A good first stop bit in two-stop mode waits for the wrap; every other
      // outcome leaves at the decision tick so the next start edge is not missed.
      STOP1: if (decide) begin
          if (brk) begin
            state_d = BRK_WAIT;
            brk_d   = 1'b1;
          end else if (!maj || !ts_q) begin
            ferr_d  = ~maj;
            state_d = PUSH;
          end
        end else if (wrap && ts_q) state_d = STOP2;
      STOP2: if (decide) begin
          ferr_d  = ferr_q | ~maj;
          state_d = PUSH;
        end
      PUSH: state_d = IDLE;
      BRK_WAIT: if (tick_ovs && rxs_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_d  = wr_q + PW'(wr_ok);
    rd_d  = rd_q + PW'(pop);
    cnt_d = cnt_q + CW'(wr_ok) - CW'(pop);
    ovr_d = (push && !wr_ok) ? 1'b1 : overrun_clr ? 1'b0 : ovr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q     <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= IDLE;
      os_q       <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      samp_q     <= '0;
      pm_q       <= '0;
      ts_q       <= 1'b0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      meta_q     <= rx_pin;
      rxs_q      <= meta_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      os_q       <= os_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      pm_q       <= pm_d;
      ts_q       <= ts_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      ovr_q      <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_q] <= {ferr_q, perr_q, shift_q};
  end

  // Storage is not reset, so the head is masked to zero while the FIFO is empty.
  assign head          = mem[rd_q];
  assign rx_valid      = cnt_q != '0;
  assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_parity_err = rx_valid & head[DATA_BITS];
  assign rx_frame_err  = rx_valid & head[DATA_BITS+1];
  assign fifo_count    = cnt_q;
  assign overrun       = ovr_q;
  assign rx_break      = brk_q;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed self-checking bench for uart_rx_buffered
module tb_uart_rx_buffered;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_ovs;
  logic       rx_pin = 1'b1;
  logic [1:0] parity_mode = 2'b00;
  logic       two_stop = 1'b0;
  logic [7:0] rx_data;
  logic       rx_parity_err, rx_frame_err, rx_valid;
  logic       rx_ready = 1'b0;
  logic [3:0] fifo_count;
  logic       overrun;
  logic       overrun_clr = 1'b0;
  logic       rx_break;
  logic [1:0] tcnt = '0;
  int         checks = 0;
  int         failures = 0;
  int         brk_cnt = 0;
  int         brk_base;

  uart_rx_buffered dut (
    .clk(clk), .reset(reset), .tick_ovs(tick_ovs), .rx_pin(rx_pin),
    .parity_mode(parity_mode), .two_stop(two_stop), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .fifo_count(fifo_count), .overrun(overrun),
    .overrun_clr(overrun_clr), .rx_break(rx_break)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcnt <= tcnt + 2'd1;
  assign tick_ovs = tcnt == 2'd3;
  always @(negedge clk) if (rx_break) brk_cnt <= brk_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] bits, input int n, input int bclk, input int g);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < bclk; c++) begin
        @(negedge clk);
        rx_pin = (i == g && c >= 35 && c < 39) ? ~bits[i] : bits[i];
      end
    @(negedge clk);
    rx_pin = 1'b1;
  endtask

  task automatic pop1;
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    idle(2);
    chk("rst_valid", rx_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_perr", rx_parity_err, 0);
    chk("rst_ferr", rx_frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_break", rx_break, 0);
    rx_ready = 1'b1;
    idle(3);
    rx_ready = 1'b0;
    chk("empty_pop_count", fifo_count, 0);
    chk("empty_pop_valid", rx_valid, 0);
    send({21'h1FFFFF, 1'b1, 8'hA5, 1'b0}, 10, 64, -1);
    idle(8);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid", rx_valid, 1);
    chk("a5_perr", rx_parity_err, 0);
    chk("a5_ferr", rx_frame_err, 0);
    chk("a5_count", fifo_count, 1);
    pop1();
    chk("a5_popped", rx_valid, 0);
    parity_mode = 2'b01;
    send({20'hFFFFF, 1'b1, 1'b0, 8'h37, 1'b0}, 11, 64, -1);
    idle(8);
    chk("odd_ok_data", rx_data, 8'h37);
    chk("odd_ok_perr", rx_parity_err, 0);
    pop1();
    send({20'hFFFFF, 1'b1, 1'b1, 8'h37, 1'b0}, 11, 64, -1);
    idle(8);
    chk("odd_bad_data", rx_data, 8'h37);
    chk("odd_bad_perr", rx_parity_err, 1);
    chk("odd_bad_ferr", rx_frame_err, 0);
    pop1();
    parity_mode = 2'b00;
    two_stop = 1'b1;
    send({19'h7FFFF, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0}, 12, 64, -1);
    idle(8);
    chk("stop2_data", rx_data, 8'h5A);
    chk("stop2_ferr", rx_frame_err, 1);
    chk("stop2_perr", rx_parity_err, 0);
    pop1();
    two_stop = 1'b0;
    @(negedge clk);
    rx_pin = 1'b0;
    idle(12);
    rx_pin = 1'b1;
    idle(200);
    chk("false_start_count", fifo_count, 0);
    send({21'h1FFFFF, 1'b1, 8'hC3, 1'b0}, 10, 64, 1);
    idle(8);
    chk("glitch_data", rx_data, 8'hC3);
    chk("glitch_count", fifo_count, 1);
    pop1();
    for (int i = 1; i <= 9; i++) send({21'h1FFFFF, 1'b1, 8'(i), 1'b0}, 10, 64, -1);
    idle(8);
    chk("ovr_count", fifo_count, 8);
    chk("ovr_flag", overrun, 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), rx_data, i);
      pop1();
    end
    chk("drain_empty", rx_valid, 0);
    chk("ovr_sticky", overrun, 1);
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    brk_base = brk_cnt;
    rx_pin = 1'b0;
    idle(1280);
    rx_pin = 1'b1;
    idle(200);
    chk("break_pulses", brk_cnt - brk_base, 1);
    chk("break_count", fifo_count, 0);
    send({12'hFFF, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}, 20, 62, -1);
    idle(8);
    chk("b2b_count", fifo_count, 2);
    chk("b2b_first", rx_data, 8'h11);
    pop1();
    chk("b2b_second", rx_data, 8'h22);
    chk("b2b_second_ferr", rx_frame_err, 0);
    pop1();
    chk("b2b_empty", rx_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
